// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, addresses the instruction ROM and
// fills the IF/ID register, with stall, redirect and end-of-program halt.
module instr_fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] PROG_LEN  = 16'h0004,
    parameter logic [31:0] NOP_INSTR = 32'hD503201F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    output logic [15:0] rom_addr,
    input  logic [31:0] rom_data,
    output logic [31:0] if_id_instr,
    output logic [15:0] if_id_pc,
    output logic        if_id_valid,
    output logic        halted
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [15:0] ipc_q, ipc_d;
    logic        valid_q, valid_d;

    assign rom_addr    = pc_q;
    assign if_id_instr = instr_q;
    assign if_id_pc    = ipc_q;
    assign if_id_valid = valid_q;
    assign halted      = (state_q == HALT);

    // Next PC, next IF/ID contents and next state; redirect beats stall.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        valid_d = valid_q;
        if (branch_taken) begin
            state_d = RUN;
            pc_d    = branch_target;
            instr_d = NOP_INSTR;
            ipc_d   = 16'h0000;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (pc_q >= PROG_LEN) begin
                        // Last real word already went to decode,
                        // so the bubble goes in even under stall.
                        state_d = HALT;
                        instr_d = NOP_INSTR;
                        ipc_d   = 16'h0000;
                        valid_d = 1'b0;
                    end else if (!stall) begin
                        pc_d    = pc_q + 16'd1;
                        instr_d = rom_data;
                        ipc_d   = pc_q;
                        valid_d = 1'b1;
                    end
                end
                HALT: begin
                    state_d = HALT;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    // State, PC and IF/ID registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            ipc_q   <= 16'h0000;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table for the
// documented sequences, then random stimulus against a rule-level model.
module tb_instr_fetch_unit;

    localparam logic [15:0] RST_PC = 16'h0000;
    localparam logic [15:0] LEN    = 16'h0004;
    localparam logic [31:0] NOP    = 32'hD503201F;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_target = 16'h0000;
    logic [15:0] rom_addr;
    logic [31:0] rom_data;
    logic [31:0] if_id_instr;
    logic [15:0] if_id_pc;
    logic        if_id_valid;
    logic        halted;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [15:0] a);
        return {16'hA0C3, a ^ 16'h3C5A};
    endfunction

    assign rom_data = rom_word(rom_addr);

    instr_fetch_unit #(
        .RESET_PC (RST_PC),
        .PROG_LEN (LEN),
        .NOP_INSTR(NOP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .if_id_instr  (if_id_instr),
        .if_id_pc     (if_id_pc),
        .if_id_valid  (if_id_valid),
        .halted       (halted)
    );

    typedef struct {
        logic        rst;
        logic        stl;
        logic        br;
        logic [15:0] tgt;
        logic [15:0] addr;
        logic        vld;
        logic [15:0] ipc;
        logic [31:0] instr;
        logic        hlt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic        rst, stl, br,
        input logic [15:0] tgt, addr,
        input logic        vld,
        input logic [15:0] ipc,
        input logic        hlt
    );
        vec_t v;
        v.rst   = rst;
        v.stl   = stl;
        v.br    = br;
        v.tgt   = tgt;
        v.addr  = addr;
        v.vld   = vld;
        v.ipc   = vld ? ipc : 16'h0000;
        v.instr = vld ? rom_word(ipc) : NOP;
        v.hlt   = hlt;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s step %0d: got %h expected %h",
                      nm, idx, act, exp);
    endtask

    task automatic check_all(input int idx, input logic [15:0] addr,
                             input logic vld, input logic [15:0] ipc,
                             input logic [31:0] instr, input logic hlt);
        chk("rom_addr", idx, 32'(rom_addr), 32'(addr));
        chk("if_id_valid", idx, 32'(if_id_valid), 32'(vld));
        chk("if_id_pc", idx, 32'(if_id_pc), 32'(ipc));
        chk("if_id_instr", idx, if_id_instr, instr);
        chk("halted", idx, 32'(halted), 32'(hlt));
    endtask

    // Rule-level reference state.
    logic [15:0] m_pc;
    logic [31:0] m_instr;
    logic [15:0] m_ipc;
    logic        m_vld;
    logic        m_hlt;

    task automatic model_step(input logic rst, stl, br,
                              input logic [15:0] tgt);
        if (rst || br) begin
            m_pc    = rst ? RST_PC : tgt;
            m_instr = NOP;
            m_ipc   = 16'h0000;
            m_vld   = 1'b0;
            m_hlt   = 1'b0;
        end else if (m_hlt) begin
            m_hlt = 1'b1;
        end else if (m_pc >= LEN) begin
            m_hlt   = 1'b1;
            m_instr = NOP;
            m_ipc   = 16'h0000;
            m_vld   = 1'b0;
        end else if (!stl) begin
            m_instr = rom_word(m_pc);
            m_ipc   = m_pc;
            m_vld   = 1'b1;
            m_pc    = m_pc + 16'd1;
        end
    endtask

    initial begin
        // Directed timeline: inputs for one edge, outputs after it.
        // 1: reset then free run to halt
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 2, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 3, 1, 2, 0));
        vecs.push_back(mk(0, 0, 0, 0, 4, 1, 3, 0));
        vecs.push_back(mk(0, 0, 0, 0, 4, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 4, 0, 0, 1));
        // 2: stall at PC=2
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 2, 1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 2, 1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 2, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 3, 1, 2, 0));
        // 3: branch to 1 at PC=3
        vecs.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 2, 1, 1, 0));
        // 4: stall and branch together
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0));
        // 5: reach halt, branch out, then branch past end
        vecs.push_back(mk(0, 0, 0, 0, 2, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 3, 1, 2, 0));
        vecs.push_back(mk(0, 0, 0, 0, 4, 1, 3, 0));
        vecs.push_back(mk(0, 1, 0, 0, 4, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 2, 2, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 3, 1, 2, 0));
        vecs.push_back(mk(0, 0, 1, 16'h10, 16'h10, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 16'h10, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 16'h10, 0, 0, 1));
        // 6: reset with stall mid-run, and reset beating a branch
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 2, 1, 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 3, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0));

        foreach (vecs[i]) begin
            reset         = vecs[i].rst;
            stall         = vecs[i].stl;
            branch_taken  = vecs[i].br;
            branch_target = vecs[i].tgt;
            @(posedge clk);
            #1;
            check_all(i, vecs[i].addr, vecs[i].vld, vecs[i].ipc,
                      vecs[i].instr, vecs[i].hlt);
        end

        // Random phase, model starts from a reset.
        m_pc = 16'hFFFF; m_instr = '0; m_ipc = '0;
        m_vld = 1'b0; m_hlt = 1'b0;
        for (int i = 0; i < 400; i++) begin
            logic        r, s, b;
            logic [15:0] t;
            r = (i == 0) || ($urandom_range(0, 49) == 0);
            s = ($urandom_range(0, 9) < 3);
            b = ($urandom_range(0, 9) == 0);
            t = ($urandom_range(0, 7) == 0) ?
                16'($urandom) : 16'($urandom_range(0, 5));
            reset         = r;
            stall         = s;
            branch_taken  = b;
            branch_target = t;
            model_step(r, s, b, t);
            @(posedge clk);
            #1;
            check_all(1000 + i, m_pc, m_vld, m_ipc, m_instr, m_hlt);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage that drives the instruction ROM: it holds the program counter, presents a 16-bit word address to the ROM, and captures the returned 32-bit instruction into the IF/ID pipeline register. It handles stalls from hazard detection and branch redirects from the execute/memory stage, and halts cleanly once the end of the program is reached. It sits between the ROM and the decode stage of the pipelined core.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset (word address).
PROG_LEN, 16'h0004, number of valid instruction words; fetch halts when PC >= PROG_LEN.
NOP_INSTR, 32'hD503201F, encoding inserted into IF/ID on bubbles and flushes.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
stall  input  1  hazard stall; holds PC and IF/ID.
branch_taken  input  1  redirect request from a later stage.
branch_target  input  16  word address to fetch after a redirect.
rom_addr  output  16  address to the ROM; equals the current PC (combinational from the PC register).
rom_data  input  32  instruction returned by the ROM for rom_addr in the same cycle (combinational ROM).
if_id_instr  output  32  registered instruction to decode.
if_id_pc  output  16  registered PC of if_id_instr.
if_id_valid  output  1  if_id_instr is a real fetched instruction.
halted  output  1  fetch stopped at end of program.

Behaviour:
- Reset (sampled at the clock edge): PC=RESET_PC; if_id_instr=NOP_INSTR; if_id_pc=16'h0000; if_id_valid=0; halted=0; state=RUN. Reset overrides every other input, including during a stall or a redirect.
- State machine: RUN, HALT.
- RUN with PC < PROG_LEN, no stall, no branch:
  - IF/ID <= {rom_data, PC, valid=1}.
  - PC <= PC+1 (16-bit, wraps FFFF->0000).
  - Latency: the address is presented in cycle N, and the instruction appears on the IF/ID outputs in cycle N+1.
- stall=1, branch_taken=0: PC and all IF/ID outputs hold their values exactly.
- branch_taken=1 (takes priority over stall, in either state):
  - PC <= branch_target.
  - IF/ID <= {NOP_INSTR, 16'h0000, valid=0}, which flushes the wrong-path fetch.
  - state <= RUN; halted <= 0.
- RUN with PC >= PROG_LEN, no branch:
  - state <= HALT; halted <= 1.
  - IF/ID <= bubble {NOP_INSTR, 0, valid=0}. This is applied even when stall=1, because the final instruction has already been handed to decode.
  - PC holds.
- HALT: PC holds, IF/ID holds the bubble, and halted=1. Only branch_taken=1 (to any target) or reset leaves HALT.
- Redirect to a target >= PROG_LEN: the next cycle enters HALT through the RUN rule. The ROM output for an out-of-range address is never captured with valid=1.
- rom_addr always equals PC, including in HALT and during stall.

Test Plan:
1. Reset, then 6 free-running cycles with PROG_LEN=4 and the ROM holding words A0..A3.
   - rom_addr runs 0,1,2,3,4,4.
   - if_id_valid=1 with if_id_pc 0,1,2,3 over cycles 2-5.
   - Then halted=1, if_id_valid=0 and if_id_instr=NOP_INSTR.
2. stall=1 for 2 cycles while PC=2.
   - rom_addr stays 2.
   - if_id_pc stays 1 with the same instruction.
   - After stall drops, the fetch of address 2 reaches IF/ID with valid=1.
3. branch_taken=1 with target=16'h0001 while PC=3.
   - Next cycle: PC=1, if_id_valid=0, if_id_instr=NOP_INSTR.
   - The cycle after: if_id_pc=1 holding the ROM word at address 1.
4. stall=1 and branch_taken=1 together, target=0.
   - Branch wins: PC=0 and IF/ID is flushed to the bubble.
5. In HALT, branch_taken=1 with target=2.
   - halted drops to 0 and fetch resumes from address 2.
   - Separately, a branch to target=16'h0010 enters HALT without ever asserting valid.
6. Assert reset for one cycle mid-run at PC=2 with stall=1.
   - All outputs return to their reset values.
   - PC=RESET_PC and fetch restarts from 0.
